cp0_interrupt_ctrl: RTL and testbench
=====================================

Name: cp0_interrupt_ctrl

Overview:
Coprocessor-0 interrupt controller for the 3-stage pipeline. It holds the Status, Cause, EPC, Count and Compare registers and services MTC0/MFC0 from the decoder's copWE/copOut strobes. It latches external and timer interrupt sources, raises InterruptRequest to the decoder, and on the decoder's InterruptHandled it captures the resume PC into EPC and redirects fetch to the ISR vector.

Parameters:
ISR_VECTOR, 32'h0000_0180, PC loaded when an interrupt is taken
COUNT_WIDTH, 32, width of the Count and Compare registers (zero-extended to 32 on read)

Ports:
clk  in  1  system clock
rst  in  1  reset
cop_we  in  1  MTC0 write strobe (decoder copWE)
cop_re  in  1  MFC0 read strobe (decoder copOut)
cop_addr  in  5  CP0 register number (instruction rd field)
cop_wdata  in  32  MTC0 write data (RegRtE)
cop_rdata  out  32  MFC0 read data
resume_pc  in  32  PC of the first unexecuted instruction at the handled point
irq_in  in  7  external interrupt lines, level in, rising-edge sensitive
interrupt_request  out  1  to decoder InterruptRequest
interrupt_handled  in  1  from decoder InterruptHandled
pc_redirect  out  1  fetch redirect strobe
pc_target  out  32  redirect target

Behaviour:
- Single clock domain, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Register map, addressed by cop_addr:
  - 9 = Count. Increments by 1 every cycle and wraps modulo 2^COUNT_WIDTH. Writable; the written value takes effect the next cycle.
  - 11 = Compare. Writing it clears IP[7].
  - 12 = Status. Bit 0 = IE; bits 15:8 = IM. All other bits read 0 and ignore writes.
  - 13 = Cause. Bits 15:8 = IP. Writing clears each IP bit whose wdata bit is 1 (W1C). Other bits read 0.
  - 14 = EPC. Read/write.
  - Any other address reads 0 and ignores writes.
- cop_rdata is combinational from cop_addr and the current register value; it is 0 when cop_re = 0.
- Interrupt sources:
  - irq_in is registered once per cycle. A 0→1 transition on line k sets IP[k] (k = 0..6).
  - IP[7] is set on the cycle Count == Compare.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
  - If Count == Compare and a Compare write occur in the same cycle, the write wins and IP[7] is cleared.
- pend = |(IP & IM).
- FSM states:
  - IDLE: interrupt_request = 0. Go to PENDING when IE & pend.
  - PENDING: interrupt_request = 1.
    - Go back to IDLE if IE or pend drops.
    - On interrupt_handled = 1:
      - EPC ← resume_pc
      - IE ← 0
      - pc_redirect = 1 for that cycle (combinational), pc_target = ISR_VECTOR
      - go to SERVICE
  - SERVICE: interrupt_request = 0.
    - Leave when software writes Status with IE = 1.
    - Next state is PENDING if the new IE & pend is true, otherwise IDLE.
- interrupt_handled in IDLE or SERVICE is ignored: no EPC update, no redirect.
- A software write to EPC on the same cycle as a handled interrupt loses; the hardware capture wins.
- pc_target is always ISR_VECTOR. pc_redirect is 1 only in the handled cycle.
- Reset values:
  - State IDLE.
  - Status, Cause, EPC, Count and Compare all 0; the irq_in sample register is 0.
  - Outputs: interrupt_request 0, pc_redirect 0, cop_rdata 0.
  - A reset mid-SERVICE abandons the interrupt; EPC clears.

Test Plan:
- Reset, then write Status = 0x0000_8001 and Compare = 10 → IP[7] sets when Count = 10; interrupt_request = 1 the following cycle; Cause reads 0x0000_8000.
- In PENDING, drive interrupt_handled with resume_pc = 0x0000_0420 → pc_redirect pulses for one cycle with pc_target 0x180; EPC reads 0x420; Status reads 0x8000; interrupt_request = 0.
- irq_in[2] rises while IM[2] = 0 → IP[2] = 1 and no request. Set IM[2] with IE = 1 → request asserts. W1C Cause with 0x400 → IP[2] clears and the request drops.
- In the same cycle, an irq_in[0] rising edge and a W1C of 0x100 → IP[0] remains 1.
- interrupt_handled pulsed in IDLE → no redirect and EPC unchanged. Assert rst while in SERVICE → all registers 0 and state IDLE next cycle.
- Write Count = 0xFFFF_FFFF → Count reads 0 one cycle later (wrap). MFC0 of address 20 → 0.

Source files
------------

// File: rtl/cp0_interrupt_ctrl.sv
// Coprocessor-0 interrupt controller: Status/Cause/EPC/Count/Compare registers,
// interrupt source latching, and the request/handled handshake with the decoder.
module cp0_interrupt_ctrl #(
    parameter logic [31:0] ISR_VECTOR  = 32'h0000_0180,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cop_we,
    input  logic        cop_re,
    input  logic [4:0]  cop_addr,
    input  logic [31:0] cop_wdata,
    output logic [31:0] cop_rdata,
    input  logic [31:0] resume_pc,
    input  logic [6:0]  irq_in,
    output logic        interrupt_request,
    input  logic        interrupt_handled,
    output logic        pc_redirect,
    output logic [31:0] pc_target
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic                   ie_q, ie_d;
    logic [7:0]             im_q, im_d;
    logic [7:0]             ip_q, ip_d;
    logic [31:0]            epc_q, epc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] compare_q, compare_d;
    logic [6:0]             irq_q;

    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic        handled_s;
    logic        pend_s;
    logic        timer_hit_s;
    logic [7:0]  ip_set_s;
    logic [7:0]  ip_clr_s;
    logic [31:0] count_ext_s;
    logic [31:0] compare_ext_s;
    logic [31:0] rdata_s;

    assign wr_count_s   = cop_we && (cop_addr == ADDR_COUNT);
    assign wr_compare_s = cop_we && (cop_addr == ADDR_COMPARE);
    assign wr_status_s  = cop_we && (cop_addr == ADDR_STATUS);
    assign wr_cause_s   = cop_we && (cop_addr == ADDR_CAUSE);
    assign wr_epc_s     = cop_we && (cop_addr == ADDR_EPC);

    assign handled_s   = (state_q == ST_PENDING) && interrupt_handled;
    assign pend_s      = |(ip_q & im_q);
    assign timer_hit_s = (count_q == compare_q);

    // Interrupt-pending bits: new sources win over W1C, a Compare write beats the timer hit.
    always_comb begin
        ip_set_s = {timer_hit_s && !wr_compare_s, irq_in & ~irq_q};
        if (wr_cause_s) begin
            ip_clr_s = cop_wdata[15:8];
        end else begin
            ip_clr_s = 8'h00;
        end
        ip_d = (ip_q & ~ip_clr_s) | ip_set_s;
        if (wr_compare_s) begin
            ip_d[7] = 1'b0;
        end else begin
            ip_d[7] = ip_d[7];
        end
    end

    // Status register; taking an interrupt forces IE low regardless of a concurrent write.
    always_comb begin
        ie_d = ie_q;
        im_d = im_q;
        if (wr_status_s) begin
            ie_d = cop_wdata[0];
            im_d = cop_wdata[15:8];
        end else begin
            ie_d = ie_q;
            im_d = im_q;
        end
        if (handled_s) begin
            ie_d = 1'b0;
        end else begin
            ie_d = ie_d;
        end
    end

    // EPC, Count and Compare next-state; hardware EPC capture beats a software write.
    always_comb begin
        if (handled_s) begin
            epc_d = resume_pc;
        end else if (wr_epc_s) begin
            epc_d = cop_wdata;
        end else begin
            epc_d = epc_q;
        end

        if (wr_count_s) begin
            count_d = cop_wdata[COUNT_WIDTH-1:0];
        end else begin
            count_d = count_q + COUNT_ONE;
        end

        if (wr_compare_s) begin
            compare_d = cop_wdata[COUNT_WIDTH-1:0];
        end else begin
            compare_d = compare_q;
        end
    end

    // Request/service state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ie_q && pend_s) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (interrupt_handled) begin
                    state_d = ST_SERVICE;
                end else if (!(ie_q && pend_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_SERVICE: begin
                // Re-arm decision uses the mask being written, not the stale one.
                if (wr_status_s && cop_wdata[0]) begin
                    if (|(ip_q & cop_wdata[15:8])) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Zero-extend the timer registers to the 32-bit read bus.
    always_comb begin
        count_ext_s                     = 32'h0000_0000;
        count_ext_s[COUNT_WIDTH-1:0]    = count_q;
        compare_ext_s                   = 32'h0000_0000;
        compare_ext_s[COUNT_WIDTH-1:0]  = compare_q;
    end

    // MFC0 read mux.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (cop_re) begin
            case (cop_addr)
                ADDR_COUNT:   rdata_s = count_ext_s;
                ADDR_COMPARE: rdata_s = compare_ext_s;
                ADDR_STATUS:  rdata_s = {16'h0000, im_q, 7'h00, ie_q};
                ADDR_CAUSE:   rdata_s = {16'h0000, ip_q, 8'h00};
                ADDR_EPC:     rdata_s = epc_q;
                default:      rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ie_q      <= 1'b0;
            im_q      <= 8'h00;
            ip_q      <= 8'h00;
            epc_q     <= 32'h0000_0000;
            count_q   <= {COUNT_WIDTH{1'b0}};
            compare_q <= {COUNT_WIDTH{1'b0}};
            irq_q     <= 7'h00;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            im_q      <= im_d;
            ip_q      <= ip_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            irq_q     <= irq_in;
        end
    end

    assign cop_rdata         = rdata_s;
    assign interrupt_request = (state_q == ST_PENDING);
    assign pc_redirect       = handled_s;
    assign pc_target         = ISR_VECTOR;

endmodule

// File: tb/tb_cp0_interrupt_ctrl.sv
// Directed self-checking bench for cp0_interrupt_ctrl.
module tb_cp0_interrupt_ctrl;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    logic        clk = 1'b0;
    logic        rst;
    logic        cop_we;
    logic        cop_re;
    logic [4:0]  cop_addr;
    logic [31:0] cop_wdata;
    logic [31:0] cop_rdata;
    logic [31:0] resume_pc;
    logic [6:0]  irq_in;
    logic        interrupt_request;
    logic        interrupt_handled;
    logic        pc_redirect;
    logic [31:0] pc_target;

    int checks = 0;
    int errors = 0;

    cp0_interrupt_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cop_we            (cop_we),
        .cop_re            (cop_re),
        .cop_addr          (cop_addr),
        .cop_wdata         (cop_wdata),
        .cop_rdata         (cop_rdata),
        .resume_pc         (resume_pc),
        .irq_in            (irq_in),
        .interrupt_request (interrupt_request),
        .interrupt_handled (interrupt_handled),
        .pc_redirect       (pc_redirect),
        .pc_target         (pc_target)
    );

    always #10 clk = ~clk;

    // Advance one clock edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cop_we    = 1'b1;
        cop_addr  = a;
        cop_wdata = d;
        step();
        cop_we    = 1'b0;
        cop_wdata = 32'h0000_0000;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cop_addr = a;
        cop_re   = 1'b1;
        #1;
        d        = cop_rdata;
        cop_re   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rd(A_STATUS, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h exp 00000000", v); end
        rd(A_CAUSE, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h exp 00000000", v); end
        rd(A_EPC, v);     checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h exp 00000000", v); end
        rd(A_COUNT, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h exp 00000000", v); end
        rd(A_COMPARE, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_compare: got %h exp 00000000", v); end
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", interrupt_request); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b exp 0", pc_redirect); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        bit hit;
        hit = 1'b0;
        wr(A_COMPARE, 32'd10);
        wr(A_STATUS, 32'h0000_8001);
        for (int i = 0; i < 30 && !hit; i++) begin
            rd(A_COUNT, v);
            if (v == 32'd10) hit = 1'b1;
            else step();
        end
        checks++; if (!hit) begin errors++; $display("FAIL timer_reach: count never read 10 within 30 cycles"); end
        rd(A_CAUSE, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_cause_before: got %h exp 00000000", v); end
        step();
        rd(A_CAUSE, v); checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL timer_cause: got %h exp 00008000", v); end
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL timer_req_early: got %b exp 0", interrupt_request); end
        step();
        checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL timer_req: got %b exp 1", interrupt_request); end
    endtask

    task automatic test_handled();
        logic [31:0] v;
        interrupt_handled = 1'b1;
        resume_pc         = 32'h0000_0420;
        cop_we            = 1'b1;
        cop_addr          = A_EPC;
        cop_wdata         = 32'hDEAD_BEEF;
        #1;
        checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL handled_redirect: got %b exp 1", pc_redirect); end
        checks++; if (pc_target !== 32'h0000_0180) begin errors++; $display("FAIL handled_target: got %h exp 00000180", pc_target); end
        step();
        interrupt_handled = 1'b0;
        cop_we            = 1'b0;
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL handled_redirect_off: got %b exp 0", pc_redirect); end
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL handled_req: got %b exp 0", interrupt_request); end
        rd(A_EPC, v);    checks++; if (v !== 32'h0000_0420) begin errors++; $display("FAIL handled_epc: got %h exp 00000420", v); end
        rd(A_STATUS, v); checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL handled_status: got %h exp 00008000", v); end
        wr(A_CAUSE, 32'h0000_8000);
        wr(A_STATUS, 32'h0000_8001);
        step();
    endtask

    task automatic test_ext_irq();
        logic [31:0] v;
        irq_in = 7'b000_0100;
        step();
        rd(A_CAUSE, v); checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL irq2_cause: got %h exp 00000400", v); end
        step();
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL irq2_masked_req: got %b exp 0", interrupt_request); end
        wr(A_STATUS, 32'h0000_8401);
        step();
        checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL irq2_req: got %b exp 1", interrupt_request); end
        wr(A_CAUSE, 32'h0000_0400);
        rd(A_CAUSE, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL irq2_w1c: got %h exp 00000000", v); end
        step();
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL irq2_req_drop: got %b exp 0", interrupt_request); end
        irq_in = 7'b000_0000;
        step();
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        irq_in = 7'b000_0001;
        wr(A_CAUSE, 32'h0000_0100);
        rd(A_CAUSE, v); checks++; if (v !== 32'h0000_0100) begin errors++; $display("FAIL set_wins: got %h exp 00000100", v); end
        wr(A_CAUSE, 32'h0000_0100);
        rd(A_CAUSE, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL set_wins_clear: got %h exp 00000000", v); end
        irq_in = 7'b000_0000;
    endtask

    task automatic test_idle_handled();
        logic [31:0] v;
        interrupt_handled = 1'b1;
        resume_pc         = 32'h0000_0999;
        #1;
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL idle_redirect: got %b exp 0", pc_redirect); end
        step();
        interrupt_handled = 1'b0;
        rd(A_EPC, v); checks++; if (v !== 32'h0000_0420) begin errors++; $display("FAIL idle_epc: got %h exp 00000420", v); end
        wr(A_EPC, 32'h1234_5678);
        rd(A_EPC, v); checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL epc_write: got %h exp 12345678", v); end
    endtask

    task automatic test_count_wrap();
        logic [31:0] v;
        wr(A_COUNT, 32'hFFFF_FFFF);
        rd(A_COUNT, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_write: got %h exp ffffffff", v); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h exp 00000000", v); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] v;
        wr(5'd20, 32'hFFFF_FFFF);
        rd(5'd20, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL addr20: got %h exp 00000000", v); end
        wr(A_STATUS, 32'hFFFF_FFFE);
        rd(A_STATUS, v); checks++; if (v !== 32'h0000_FF00) begin errors++; $display("FAIL status_mask: got %h exp 0000ff00", v); end
        cop_addr = A_STATUS;
        cop_re   = 1'b0;
        #1;
        checks++; if (cop_rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_re: got %h exp 00000000", cop_rdata); end
    endtask

    task automatic test_reset_in_service();
        logic [31:0] v;
        wr(A_STATUS, 32'h0000_0201);
        irq_in = 7'b000_0010;
        step();
        step();
        checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL svc_req: got %b exp 1", interrupt_request); end
        interrupt_handled = 1'b1;
        resume_pc         = 32'h0000_0500;
        step();
        interrupt_handled = 1'b0;
        irq_in            = 7'b000_0000;
        rd(A_EPC, v); checks++; if (v !== 32'h0000_0500) begin errors++; $display("FAIL svc_epc: got %h exp 00000500", v); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(A_STATUS, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_svc_status: got %h exp 00000000", v); end
        rd(A_CAUSE, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_svc_cause: got %h exp 00000000", v); end
        rd(A_EPC, v);     checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_svc_epc: got %h exp 00000000", v); end
        rd(A_COUNT, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_svc_count: got %h exp 00000000", v); end
        rd(A_COMPARE, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_svc_compare: got %h exp 00000000", v); end
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL rst_svc_req: got %b exp 0", interrupt_request); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL rst_svc_count_run: got %h exp 00000001", v); end
        checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL rst_svc_idle: got %b exp 0", interrupt_request); end
    endtask

    initial begin
        rst               = 1'b1;
        cop_we            = 1'b0;
        cop_re            = 1'b0;
        cop_addr          = 5'd0;
        cop_wdata         = 32'h0000_0000;
        resume_pc         = 32'h0000_0000;
        irq_in            = 7'h00;
        interrupt_handled = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_timer();
        test_handled();
        test_ext_irq();
        test_set_wins();
        test_idle_handled();
        test_count_wrap();
        test_bad_addr();
        test_reset_in_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
